dual_cam_frame_arbiter: RTL

- Shares the single CSI-2 packetizer between two BT.656 sync-decoder outputs (cam0, cam1). Each source delivers data plus FV/LV.
- Grants the output at whole-frame granularity, so a frame is never split and never interleaved with the other camera's frame.
- Tags each granted frame with a virtual-channel ID and enforces a minimum inter-frame gap so the CSI-2 TX can emit FE/FS packets.
- Sits between the two sync decoders and the CSI-2 packet builder. All inputs are already synchronous to clock_in.

---
 rtl/dual_cam_frame_arbiter_pkg.sv | 33 +++
 rtl/dual_cam_frame_arbiter_fv_edge_watch.sv | 41 ++++
 rtl/dual_cam_frame_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dual_cam_frame_arbiter_pkg.sv
// dual_cam_pkg: shared state/mode types, default virtual-channel IDs and the
// mode-eligibility rule used by the dual-camera frame arbiter.
package dual_cam_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_C0  = 2'b00,
        MODE_C1  = 2'b01,
        MODE_ALT = 2'b10,
        MODE_RR  = 2'b11
    } mode_t;

    localparam logic [1:0] VC0_DEFAULT = 2'd0;
    localparam logic [1:0] VC1_DEFAULT = 2'd1;

    // Whether the operating mode lets camera `cam` take the next grant.
    // In alternate mode the very first grant after reset must go to cam0.
    function automatic logic mode_permits(input mode_t mode, input logic cam,
                                          input logic last_sel, input logic granted_before);
        case (mode)
            MODE_C0:  return !cam;
            MODE_C1:  return cam;
            MODE_ALT: return granted_before ? (cam != last_sel) : !cam;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dual_cam_frame_arbiter_fv_edge_watch.sv
// fv_edge_watch: per-camera FV history, rising-edge detect and stale flag.
// A camera marked stale (its frame was aborted by the watchdog) stays stale
// until its FV is seen low, so it cannot be re-granted mid-frame.
module fv_edge_watch
    import dual_cam_pkg::*;
(
    input  logic clock_in,
    input  logic reset_n,
    input  logic fv,
    input  logic set_stale,
    output logic rise,
    output logic stale
);

    logic fv_q;
    // The first sample after reset only loads history, so an FV that was
    // already high across reset is not mistaken for a new frame start.
    logic armed;

    // FV history, arming and stale flag; a low FV sample wins over set_stale.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            fv_q  <= 1'b0;
            armed <= 1'b0;
            stale <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every
            // register samples the pre-edge values of its neighbours.
            fv_q  <= fv;
            armed <= 1'b1;
            if (!fv) begin
                stale <= 1'b0;
            end else if (set_stale) begin
                stale <= 1'b1;
            end
        end
    end

    assign rise = fv & ~fv_q & armed;

endmodule

// File: rtl/dual_cam_frame_arbiter.sv
// dual_cam_frame_arbiter: shares one CSI-2 packetizer between two BT.656
// decoder outputs, granting whole frames, tagging them with a VC ID and
// enforcing an idle gap between frames. A watchdog aborts over-long frames.
// Optional build macro: DUAL_CAM_DROP_COUNT_EN adds saturating per-camera
// counters of rising edges that were not granted.
module dual_cam_frame_arbiter
    import dual_cam_pkg::*;
#(
    parameter int unsigned GAP_CYCLES       = 64,
    parameter int unsigned MAX_FRAME_CYCLES = 2000000,
    parameter logic [1:0]  VC0              = VC0_DEFAULT,
    parameter logic [1:0]  VC1              = VC1_DEFAULT
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic [1:0] mode,
    input  logic [7:0] c0_data,
    input  logic       c0_fv,
    input  logic       c0_lv,
    input  logic [7:0] c1_data,
    input  logic       c1_fv,
    input  logic       c1_lv,
    output logic [7:0] out_data,
    output logic       out_fv,
    output logic       out_lv,
    output logic [1:0] out_vc,
    output logic       sel,
    output logic       busy,
    output logic       timeout
`ifdef DUAL_CAM_DROP_COUNT_EN
    ,
    output logic [7:0] drop0_cnt,
    output logic [7:0] drop1_cnt
`endif
);

    localparam int unsigned    FCW        = $clog2(MAX_FRAME_CYCLES + 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(MAX_FRAME_CYCLES - 1);
    localparam logic [7:0]     GAP_LAST   = 8'(GAP_CYCLES - 1);

    state_t         state, state_d;
    logic [FCW-1:0] frame_cnt, frame_cnt_d;
    logic [7:0]     gap_cnt, gap_cnt_d;
    logic           rr_ptr, rr_ptr_d;
    logic           first_done, first_done_d;
    logic           sel_d;
    logic [1:0]     vc_d;
    logic [7:0]     data_d;
    logic           fv_d, lv_d;

    logic [1:0] fv_in, rise, stale, set_stale, elig;
    logic       wd_fire, grant, gsel;

    assign fv_in     = {c1_fv, c0_fv};
    assign wd_fire   = (state == STREAM) && (frame_cnt == FRAME_LAST);
    assign set_stale = {wd_fire & sel, wd_fire & ~sel};

    fv_edge_watch u_watch0 (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .fv        (fv_in[0]),
        .set_stale (set_stale[0]),
        .rise      (rise[0]),
        .stale     (stale[0])
    );

    fv_edge_watch u_watch1 (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .fv        (fv_in[1]),
        .set_stale (set_stale[1]),
        .rise      (rise[1]),
        .stale     (stale[1])
    );

    assign elig[0] = rise[0] & ~stale[0] & mode_permits(mode_t'(mode), 1'b0, sel, first_done);
    assign elig[1] = rise[1] & ~stale[1] & mode_permits(mode_t'(mode), 1'b1, sel, first_done);
    assign grant   = (state == IDLE) && (|elig);
    // Simultaneous eligible rises are settled by the round-robin pointer.
    assign gsel    = (&elig) ? rr_ptr : elig[1];

    assign busy    = (state != IDLE);
    // Decoded from registered state only: high in the last STREAM cycle
    // before the watchdog forces the output low.
    assign timeout = wd_fire;

    // Next-state and next-output decode for the grant/stream/gap FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state;
        frame_cnt_d  = frame_cnt;
        gap_cnt_d    = gap_cnt;
        rr_ptr_d     = rr_ptr;
        first_done_d = first_done;
        sel_d        = sel;
        vc_d         = out_vc;
        data_d       = 8'h00;
        fv_d         = 1'b0;
        lv_d         = 1'b0;

        case (state)
            IDLE: begin
                if (grant) begin
                    state_d      = STREAM;
                    frame_cnt_d  = '0;
                    sel_d        = gsel;
                    vc_d         = gsel ? VC1 : VC0;
                    rr_ptr_d     = ~gsel;
                    first_done_d = 1'b1;
                    data_d       = gsel ? c1_data : c0_data;
                    fv_d         = gsel ? c1_fv   : c0_fv;
                    lv_d         = gsel ? c1_lv   : c0_lv;
                end
            end
            STREAM: begin
                if (wd_fire) begin
                    state_d   = GAP;
                    gap_cnt_d = 8'd0;
                end else begin
                    frame_cnt_d = frame_cnt + FCW'(1);
                    data_d      = sel ? c1_data : c0_data;
                    fv_d        = sel ? c1_fv   : c0_fv;
                    lv_d        = sel ? c1_lv   : c0_lv;
                    if (!fv_d) begin
                        state_d   = GAP;
                        gap_cnt_d = 8'd0;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt + 8'd1;
                if (gap_cnt == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            gap_cnt    <= 8'd0;
            rr_ptr     <= 1'b0;
            first_done <= 1'b0;
            sel        <= 1'b0;
            out_vc     <= 2'd0;
            out_data   <= 8'h00;
            out_fv     <= 1'b0;
            out_lv     <= 1'b0;
        end else begin
            state      <= state_d;
            frame_cnt  <= frame_cnt_d;
            gap_cnt    <= gap_cnt_d;
            rr_ptr     <= rr_ptr_d;
            first_done <= first_done_d;
            sel        <= sel_d;
            out_vc     <= vc_d;
            out_data   <= data_d;
            out_fv     <= fv_d;
            out_lv     <= lv_d;
        end
    end

`ifdef DUAL_CAM_DROP_COUNT_EN
    logic [1:0] lost;
    assign lost[0] = rise[0] & ~(grant & ~gsel);
    assign lost[1] = rise[1] & ~(grant & gsel);

    // Saturating counts of frame starts that did not win the output.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            drop0_cnt <= 8'd0;
            drop1_cnt <= 8'd0;
        end else begin
            if (lost[0] && (drop0_cnt != 8'hFF)) drop0_cnt <= drop0_cnt + 8'd1;
            if (lost[1] && (drop1_cnt != 8'hFF)) drop1_cnt <= drop1_cnt + 8'd1;
        end
    end
`endif

endmodule
